dma_read_sched: RTL and testbench



---
 rtl/dma_read_sched.sv | 130 +++++++++++++
 tb/tb_dma_read_sched.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_read_sched.sv
// DMA read scheduler: splits read commands into MRRS/4KB-bounded memory-read requests, tagging each one.
// Optional statistics counters are enabled by defining DMA_RD_SCHED_STATS_EN.
module dma_read_sched #(
    parameter int MRRS_DW = 128
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [63:0] cmd_addr,
    input  logic [15:0] cmd_len_dw,
    output logic        cmd_done,
    output logic        tag_read_req,
    output logic        tag_read_last,
    input  logic        tag_read_ack,
    input  logic [4:0]  tag_read_number,
    output logic        mrd_valid,
    input  logic        mrd_ready,
    output logic [63:0] mrd_addr,
    output logic [10:0] mrd_len_dw,
    output logic [4:0]  mrd_tag,
    output logic        mrd_last,
    output logic        busy
`ifdef DMA_RD_SCHED_STATS_EN
    ,
    output logic [31:0] stat_req_cnt,
    output logic [31:0] stat_tag_wait
`endif
);

    typedef enum logic [1:0] {IDLE, SPLIT, TAG, ISSUE} state_t;

    localparam logic [15:0] MRRS_W = 16'(MRRS_DW);

    state_t      state;
    state_t      state_nxt;
    logic [63:0] addr_q;
    logic [15:0] rem_q;
    logic        done_q;
    logic [10:0] chunk_nxt;
    logic        chunk_last_nxt;

    // Largest request allowed by remaining length, MRRS and distance to the next 4 KB page.
    function automatic logic [10:0] chunk_size(input logic [15:0] rem, input logic [9:0] dw_in_page);
        logic [10:0] to_page;
        logic [15:0] c;
        to_page = 11'd1024 - {1'b0, dw_in_page};
        c = rem;
        if (c > MRRS_W) c = MRRS_W;
        if (c > {5'd0, to_page}) c = {5'd0, to_page};
        return c[10:0];
    endfunction

    assign chunk_nxt      = chunk_size(rem_q, addr_q[11:2]);
    assign chunk_last_nxt = ({5'd0, chunk_nxt} == rem_q);
    assign cmd_done       = done_q;

    always_comb begin
        state_nxt     = state;
        cmd_ready     = 1'b0;
        tag_read_req  = 1'b0;
        tag_read_last = 1'b0;
        mrd_valid     = 1'b0;
        busy          = 1'b1;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                if (cmd_valid && cmd_len_dw != 16'd0) state_nxt = SPLIT;
            end
            SPLIT: state_nxt = TAG;
            TAG: begin
                tag_read_req  = 1'b1;
                tag_read_last = mrd_last;
                if (tag_read_ack) state_nxt = ISSUE;
            end
            ISSUE: begin
                mrd_valid = 1'b1;
                if (mrd_ready) state_nxt = mrd_last ? IDLE : SPLIT;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Control and descriptor registers; the descriptor is loaded in SPLIT and stays frozen through TAG/ISSUE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            done_q     <= 1'b0;
            mrd_addr   <= 64'd0;
            mrd_len_dw <= 11'd0;
            mrd_tag    <= 5'd0;
            mrd_last   <= 1'b0;
        end else begin
            state  <= state_nxt;
            done_q <= (state == IDLE && cmd_valid && cmd_len_dw == 16'd0) ||
                      (state == ISSUE && mrd_ready && mrd_last);
            if (state == SPLIT) begin
                mrd_addr   <= addr_q;
                mrd_len_dw <= chunk_nxt;
                mrd_last   <= chunk_last_nxt;
            end
            if (state == TAG && tag_read_ack) mrd_tag <= tag_read_number;
        end
    end

    // Working address and remaining length; only meaningful while busy.
    always_ff @(posedge clk) begin
        if (state == IDLE && cmd_valid) begin
            addr_q <= cmd_addr & ~64'd3;
            rem_q  <= cmd_len_dw;
        end else if (state == ISSUE && mrd_ready) begin
            addr_q <= addr_q + {51'd0, mrd_len_dw, 2'b00};
            rem_q  <= rem_q - {5'd0, mrd_len_dw};
        end
    end

`ifdef DMA_RD_SCHED_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_req_cnt  <= 32'd0;
            stat_tag_wait <= 32'd0;
        end else begin
            if (state == ISSUE && mrd_ready) stat_req_cnt <= stat_req_cnt + 32'd1;
            if (state == TAG && !tag_read_ack) stat_tag_wait <= stat_tag_wait + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dma_read_sched.sv
// Self-checking bench for dma_read_sched: randomized commands, tag manager and TLP-builder models,
// descriptors compared against a page/MRRS split computed from the command.
module tb_dma_read_sched;

    localparam int MRRS = 128;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [63:0] cmd_addr = 64'd0;
    logic [15:0] cmd_len_dw = 16'd0;
    logic        cmd_done;
    logic        tag_read_req;
    logic        tag_read_last;
    logic        tag_read_ack = 1'b0;
    logic [4:0]  tag_read_number = 5'd0;
    logic        mrd_valid;
    logic        mrd_ready = 1'b0;
    logic [63:0] mrd_addr;
    logic [10:0] mrd_len_dw;
    logic [4:0]  mrd_tag;
    logic        mrd_last;
    logic        busy;
`ifdef DMA_RD_SCHED_STATS_EN
    logic [31:0] stat_req_cnt;
    logic [31:0] stat_tag_wait;
`endif

    dma_read_sched #(.MRRS_DW(MRRS)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
        .cmd_len_dw(cmd_len_dw), .cmd_done(cmd_done),
        .tag_read_req(tag_read_req), .tag_read_last(tag_read_last),
        .tag_read_ack(tag_read_ack), .tag_read_number(tag_read_number),
        .mrd_valid(mrd_valid), .mrd_ready(mrd_ready), .mrd_addr(mrd_addr),
        .mrd_len_dw(mrd_len_dw), .mrd_tag(mrd_tag), .mrd_last(mrd_last),
        .busy(busy)
`ifdef DMA_RD_SCHED_STATS_EN
        , .stat_req_cnt(stat_req_cnt), .stat_tag_wait(stat_tag_wait)
`endif
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    logic [63:0] exp_addr[$];
    int          exp_len[$];
    bit          exp_last[$];
    logic [63:0] obs_addr[$];
    int          obs_len[$];
    bit          obs_last[$];
    logic [4:0]  obs_tag[$];
    logic [4:0]  given_tag[$];
    bit          given_last[$];
    int          lat;
    int          req_hi;
    int          wait_sum;
    int          force_tag = -1;

    // Reference split: walk the command, each request bounded by remaining length, MRRS and page end.
    task automatic build_model(input logic [63:0] a, input int len);
        logic [63:0] p;
        int rem, to_page, c;
        exp_addr.delete(); exp_len.delete(); exp_last.delete();
        p = a & ~64'd3;
        rem = len;
        while (rem > 0) begin
            to_page = (4096 - int'(p % 64'd4096)) / 4;
            c = rem;
            if (c > MRRS) c = MRRS;
            if (c > to_page) c = to_page;
            exp_addr.push_back(p);
            exp_len.push_back(c);
            exp_last.push_back(c == rem);
            p = p + 64'(c) * 64'd4;
            rem -= c;
        end
    endtask

    task automatic run_cmd(input string name, input logic [63:0] a, input int len,
                           input int amin, input int amax, input int rmin, input int rmax);
        int cyc, budget, ack_d, rdy_d, req_run, rdy_run, exp_lat;
        bit in_issue, overlap_err, stall_err, busy_err, done_seen;
        logic [80:0] snap;
`ifdef DMA_RD_SCHED_STATS_EN
        logic [31:0] req0, wait0;
`endif
        build_model(a, len);
        obs_addr.delete(); obs_len.delete(); obs_last.delete(); obs_tag.delete();
        given_tag.delete(); given_last.delete();
        budget = 64 + exp_addr.size() * (amax + rmax + 8);
        ack_d = $urandom_range(amax, amin);
        rdy_d = $urandom_range(rmax, rmin);
        req_run = 0; rdy_run = 0; exp_lat = 1; req_hi = 0; wait_sum = 0; lat = -1;
        in_issue = 0; overlap_err = 0; stall_err = 0; busy_err = 0; done_seen = 0;
        snap = '0;

        @(negedge clk);
        cmd_valid = 1'b1; cmd_addr = a; cmd_len_dw = 16'(len);
        n_chk++;
        if (cmd_ready !== 1'b1) $display("FAIL %s cmd_ready at accept: got %b want 1", name, cmd_ready);
        else n_pass++;
`ifdef DMA_RD_SCHED_STATS_EN
        req0 = stat_req_cnt; wait0 = stat_tag_wait;
`endif
        @(posedge clk);
        cyc = 0;
        while (!done_seen && cyc < budget) begin
            @(negedge clk);
            cyc++;
            cmd_valid = 1'b0; tag_read_ack = 1'b0; mrd_ready = 1'b0;
            if (cmd_done === 1'b1) begin
                done_seen = 1; lat = cyc;
            end
            if (cyc == 1 && len != 0 && busy !== 1'b1) busy_err = 1;
            if (tag_read_req === 1'b1 && mrd_valid === 1'b1) overlap_err = 1;
            if (tag_read_req === 1'b1) begin
                req_hi++; req_run++;
                if (req_run == ack_d + 1) begin
                    tag_read_ack = 1'b1;
                    tag_read_number = (force_tag >= 0) ? 5'(force_tag) : 5'($urandom_range(31, 0));
                    given_tag.push_back(tag_read_number);
                    given_last.push_back(tag_read_last);
                    exp_lat += 3 + ack_d;
                    wait_sum += ack_d;
                    req_run = 0;
                    ack_d = $urandom_range(amax, amin);
                end
            end
            if (mrd_valid === 1'b1) begin
                if (!in_issue) begin
                    in_issue = 1; rdy_run = 0;
                    snap = {mrd_addr, mrd_len_dw, mrd_tag, mrd_last};
                end else if (snap !== {mrd_addr, mrd_len_dw, mrd_tag, mrd_last}) begin
                    stall_err = 1;
                end
                if (rdy_run == rdy_d) begin
                    mrd_ready = 1'b1;
                    obs_addr.push_back(mrd_addr); obs_len.push_back(int'(mrd_len_dw));
                    obs_last.push_back(mrd_last); obs_tag.push_back(mrd_tag);
                    exp_lat += rdy_d;
                    in_issue = 0;
                    rdy_d = $urandom_range(rmax, rmin);
                end else begin
                    rdy_run++;
                end
            end
        end

        n_chk++;
        if (!done_seen) $display("FAIL %s cmd_done timeout: got none in %0d cycles, want one", name, budget);
        else n_pass++;
        n_chk++;
        if (lat !== exp_lat) $display("FAIL %s done latency: got %0d want %0d", name, lat, exp_lat);
        else n_pass++;
        n_chk++;
        if (obs_addr.size() !== exp_addr.size())
            $display("FAIL %s descriptor count: got %0d want %0d", name, obs_addr.size(), exp_addr.size());
        else n_pass++;
        for (int i = 0; i < exp_addr.size() && i < obs_addr.size(); i++) begin
            n_chk++;
            if ({obs_addr[i], obs_len[i], obs_last[i]} !== {exp_addr[i], exp_len[i], exp_last[i]})
                $display("FAIL %s desc[%0d]: got addr=%h len=%0d last=%0b want addr=%h len=%0d last=%0b",
                         name, i, obs_addr[i], obs_len[i], obs_last[i], exp_addr[i], exp_len[i], exp_last[i]);
            else n_pass++;
        end
        for (int i = 0; i < given_tag.size() && i < obs_tag.size() && i < exp_last.size(); i++) begin
            n_chk++;
            if ({obs_tag[i], given_last[i]} !== {given_tag[i], exp_last[i]})
                $display("FAIL %s tag[%0d]: got tag=%0d tag_last=%0b want tag=%0d tag_last=%0b",
                         name, i, obs_tag[i], given_last[i], given_tag[i], exp_last[i]);
            else n_pass++;
        end
        n_chk++;
        if ({overlap_err, stall_err, busy_err} !== 3'b000)
            $display("FAIL %s protocol: got overlap=%0b stall_change=%0b busy_err=%0b want all 0",
                     name, overlap_err, stall_err, busy_err);
        else n_pass++;
        n_chk++;
        if ({busy, cmd_ready} !== 2'b01)
            $display("FAIL %s idle at done: got busy=%b cmd_ready=%b want busy=0 cmd_ready=1", name, busy, cmd_ready);
        else n_pass++;
`ifdef DMA_RD_SCHED_STATS_EN
        n_chk++;
        if ({stat_req_cnt - req0, stat_tag_wait - wait0} !== {32'(exp_addr.size()), 32'(wait_sum)})
            $display("FAIL %s stats delta: got req=%0d wait=%0d want req=%0d wait=%0d", name,
                     stat_req_cnt - req0, stat_tag_wait - wait0, exp_addr.size(), wait_sum);
        else n_pass++;
`endif
        @(negedge clk);
        n_chk++;
        if (cmd_done !== 1'b0) $display("FAIL %s done single pulse: got %b want 0", name, cmd_done);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_chk++;
        if ({cmd_done, tag_read_req, tag_read_last, mrd_valid, mrd_last, busy, mrd_addr, mrd_len_dw, mrd_tag} !== '0)
            $display("FAIL reset outputs: got done=%b req=%b last=%b valid=%b mlast=%b busy=%b addr=%h len=%0d tag=%0d want all 0",
                     cmd_done, tag_read_req, tag_read_last, mrd_valid, mrd_last, busy, mrd_addr, mrd_len_dw, mrd_tag);
        else n_pass++;
        rst_n = 1'b1;
        @(negedge clk);
        n_chk++;
        if ({cmd_ready, busy} !== 2'b10) $display("FAIL reset release: got cmd_ready=%b busy=%b want 1 0", cmd_ready, busy);
        else n_pass++;
`ifdef DMA_RD_SCHED_STATS_EN
        n_chk++;
        if ({stat_req_cnt, stat_tag_wait} !== 64'd0)
            $display("FAIL reset stats: got %0d %0d want 0 0", stat_req_cnt, stat_tag_wait);
        else n_pass++;
`endif
    endtask

    task automatic test_even_split();
        run_cmd("even", 64'h1000, 256, 1, 1, 0, 0);
        n_chk++;
        if ({obs_addr.size(), obs_addr[0], obs_len[0], obs_last[0], obs_addr[1], obs_len[1], obs_last[1]} !==
            {32'd2, 64'h1000, 32'd128, 1'b0, 64'h1200, 32'd128, 1'b1})
            $display("FAIL even descs: got n=%0d (%h,%0d,%0b) (%h,%0d,%0b) want (1000,128,0) (1200,128,1)",
                     obs_addr.size(), obs_addr[0], obs_len[0], obs_last[0], obs_addr[1], obs_len[1], obs_last[1]);
        else n_pass++;
        n_chk++;
        if ({given_last.size(), given_last[0], given_last[1]} !== {32'd2, 1'b0, 1'b1})
            $display("FAIL even tag_read_last: got n=%0d %b %b want 2 0 1", given_last.size(), given_last[0], given_last[1]);
        else n_pass++;
    endtask

    task automatic test_4k_cross();
        run_cmd("cross4k", 64'h0FF0, 16, 1, 2, 0, 2);
        n_chk++;
        if ({obs_addr.size(), obs_addr[0], obs_len[0], obs_last[0], obs_addr[1], obs_len[1], obs_last[1]} !==
            {32'd2, 64'h0FF0, 32'd4, 1'b0, 64'h1000, 32'd12, 1'b1})
            $display("FAIL cross4k descs: got n=%0d (%h,%0d,%0b) (%h,%0d,%0b) want (ff0,4,0) (1000,12,1)",
                     obs_addr.size(), obs_addr[0], obs_len[0], obs_last[0], obs_addr[1], obs_len[1], obs_last[1]);
        else n_pass++;
    endtask

    task automatic test_tag_starvation();
`ifdef DMA_RD_SCHED_STATS_EN
        logic [31:0] w0;
        w0 = stat_tag_wait;
`endif
        force_tag = 7;
        run_cmd("starve", 64'h3000, 8, 20, 20, 0, 0);
        force_tag = -1;
        n_chk++;
        if ({req_hi, obs_tag[0]} !== {32'd21, 5'd7})
            $display("FAIL starve: got req_cycles=%0d tag=%0d want 21 7", req_hi, obs_tag[0]);
        else n_pass++;
`ifdef DMA_RD_SCHED_STATS_EN
        n_chk++;
        if (stat_tag_wait - w0 !== 32'd20) $display("FAIL starve stat_tag_wait: got %0d want 20", stat_tag_wait - w0);
        else n_pass++;
`endif
    endtask

    task automatic test_backpressure();
        run_cmd("backpressure", 64'h5000, 300, 1, 3, 10, 10);
        n_chk++;
        if ({obs_addr.size(), obs_addr[2], obs_len[2]} !== {32'd3, 64'h5400, 32'd44})
            $display("FAIL backpressure tail: got n=%0d addr=%h len=%0d want 3 5400 44", obs_addr.size(), obs_addr[2], obs_len[2]);
        else n_pass++;
    endtask

    task automatic test_zero_len();
        run_cmd("zero", 64'h1234, 0, 1, 1, 0, 0);
        n_chk++;
        if ({req_hi, obs_addr.size(), lat} !== {32'd0, 32'd0, 32'd1})
            $display("FAIL zero: got req_cycles=%0d descs=%0d latency=%0d want 0 0 1", req_hi, obs_addr.size(), lat);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        cmd_valid = 1'b1; cmd_len_dw = 16'd0; cmd_addr = 64'h40;
        @(negedge clk);
        n_chk++;
        if ({cmd_done, cmd_ready} !== 2'b11) $display("FAIL b2b first: got done=%b ready=%b want 1 1", cmd_done, cmd_ready);
        else n_pass++;
        @(negedge clk);
        cmd_valid = 1'b0;
        n_chk++;
        if (cmd_done !== 1'b1) $display("FAIL b2b second done: got %b want 1", cmd_done);
        else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [63:0] a;
        int len;
        for (int k = 0; k < 12; k++) begin
            a = {$urandom, $urandom};
            if (k % 3 == 1) a[11:0] = 12'hF00 | 12'($urandom_range(255, 0));
            if (k == 5) a = 64'hFFFF_FFFF_FFFF_FE00;
            len = $urandom_range(700, 0);
            run_cmd("random", a, len, 1, 4, 0, 4);
        end
        run_cmd("max_len", 64'h0804, 65535, 1, 1, 0, 0);
    endtask

    task automatic test_reset_mid();
        int cyc;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_addr = 64'h0; cmd_len_dw = 16'd384;
        @(negedge clk);
        cmd_valid = 1'b0;
        cyc = 0;
        while (mrd_valid !== 1'b1 && cyc < 40) begin
            tag_read_ack = tag_read_req;
            mrd_ready = 1'b0;
            @(negedge clk);
            cyc++;
        end
        tag_read_ack = 1'b0;
        n_chk++;
        if (mrd_valid !== 1'b1) $display("FAIL reset_mid reach ISSUE: got mrd_valid=%b want 1", mrd_valid);
        else n_pass++;
        rst_n = 1'b0;
        #1;
        n_chk++;
        if ({cmd_done, tag_read_req, tag_read_last, mrd_valid, mrd_last, busy, mrd_addr, mrd_len_dw, mrd_tag} !== '0)
            $display("FAIL reset_mid outputs: got valid=%b busy=%b addr=%h len=%0d tag=%0d want all 0",
                     mrd_valid, busy, mrd_addr, mrd_len_dw, mrd_tag);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_cmd("post_reset", 64'h2000, 1, 1, 1, 0, 0);
        n_chk++;
        if ({obs_addr.size(), obs_addr[0], obs_len[0], obs_last[0]} !== {32'd1, 64'h2000, 32'd1, 1'b1})
            $display("FAIL post_reset desc: got n=%0d (%h,%0d,%0b) want 1 (2000,1,1)",
                     obs_addr.size(), obs_addr[0], obs_len[0], obs_last[0]);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_even_split();
        test_4k_cross();
        test_tag_starvation();
        test_backpressure();
        test_zero_len();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

endmodule
